multi_credit_counter: RTL

MULTI_CREDIT_COUNTER -- requirements
Module: multi_credit_counter

---
 rtl/multi_credit_counter.sv | 110 +++++++++++
 1 files changed

// File: rtl/multi_credit_counter.sv
// multi_credit_counter: a bank of independent, saturating credit counters.
// Each channel accepts a credit return (give) and a credit request (take)
// every cycle. A take is granted only when the registered count covers it.
// Over-returns saturate the count and raise a sticky overflow flag.
module multi_credit_counter #(
    parameter int unsigned NumChannels     = 4,
    parameter int unsigned NumCredits      = 8,
    parameter int unsigned MaxAmount       = 4,
    parameter int unsigned InitCreditEmpty = 0,
    parameter int unsigned LowThresh       = 1,
    localparam int unsigned CntWidth       = $clog2(NumCredits + 1),
    localparam int unsigned AmtWidth       = $clog2(MaxAmount + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumChannels-1:0]          init_i,
    input  logic [NumChannels-1:0]          give_valid_i,
    input  logic [NumChannels*AmtWidth-1:0] give_amt_i,
    input  logic [NumChannels-1:0]          take_valid_i,
    input  logic [NumChannels*AmtWidth-1:0] take_amt_i,
    output logic [NumChannels-1:0]          take_ready_o,
    output logic [NumChannels*CntWidth-1:0] credit_o,
    output logic [NumChannels-1:0]          credit_left_o,
    output logic [NumChannels-1:0]          credit_low_o,
    output logic [NumChannels-1:0]          credit_full_o,
    output logic [NumChannels-1:0]          overflow_o
);

    // Two guard bits: one so an over-return is visible above NumCredits,
    // one of headroom so the subtraction never wraps.
    localparam int unsigned SumWidth = CntWidth + 2;

    localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(NumCredits);
    localparam logic [CntWidth-1:0] InitCnt = (InitCreditEmpty != 0) ? '0 : MaxCnt;
    localparam logic [SumWidth-1:0] SumMax  = SumWidth'(NumCredits);
    localparam logic [AmtWidth-1:0] AmtMax  = AmtWidth'(MaxAmount);

    for (genvar c = 0; c < NumChannels; c++) begin : ch_g
        logic [AmtWidth-1:0] give_amt;
        logic [AmtWidth-1:0] take_amt;
        logic                take_legal;
        logic                take_ready;
        logic                take_fire;
        logic [SumWidth-1:0] sum;
        logic [CntWidth-1:0] cnt_q;
        logic [CntWidth-1:0] cnt_d;
        logic                ovf_q;
        logic                ovf_d;

        assign give_amt = give_amt_i[c*AmtWidth +: AmtWidth];
        assign take_amt = take_amt_i[c*AmtWidth +: AmtWidth];

        // Grant is judged on the registered count only, so a same-cycle
        // give can never fund a take; an out-of-range amount is never granted.
        assign take_legal = (take_amt <= AmtMax);
        assign take_ready = take_legal && (cnt_q >= CntWidth'(take_amt));
        assign take_fire  = take_valid_i[c] && take_ready;

        // Next-state: net delta of give and fired take, saturated, init wins.
        always_comb begin
            // NOTE: every variable gets a default before any branch so no
            // path leaves it unassigned, which would infer a latch.
            sum   = SumWidth'(cnt_q);
            cnt_d = cnt_q;
            ovf_d = ovf_q;
            if (give_valid_i[c]) begin
                sum = sum + SumWidth'(give_amt);
            end
            if (take_fire) begin
                sum = sum - SumWidth'(take_amt);
            end
            if (init_i[c]) begin
                cnt_d = InitCnt;
                ovf_d = 1'b0;
            end else if (sum > SumMax) begin
                cnt_d = MaxCnt;
                ovf_d = 1'b1;
            end else begin
                cnt_d = CntWidth'(sum);
            end
        end

        // Count and sticky overflow registers; reset overrides everything.
        always_ff @(posedge clk_i) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples its pre-edge inputs regardless of block ordering.
            if (rst_i) begin
                cnt_q <= InitCnt;
                ovf_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                ovf_q <= ovf_d;
            end
        end

        assign take_ready_o[c]                    = take_ready;
        assign credit_o[c*CntWidth +: CntWidth]   = cnt_q;
        assign credit_left_o[c]                   = (cnt_q != '0);
        assign credit_low_o[c]                    = (32'(cnt_q) <= LowThresh);
        assign credit_full_o[c]                   = (cnt_q == MaxCnt);
        assign overflow_o[c]                      = ovf_q;

        // Amounts above MaxAmount are a protocol error by the requester.
        give_amt_legal_a: assert property (@(posedge clk_i) disable iff (rst_i)
            give_valid_i[c] |-> (give_amt <= AmtMax));
        take_amt_legal_a: assert property (@(posedge clk_i) disable iff (rst_i)
            take_valid_i[c] |-> take_legal);
    end

endmodule
